// File: rtl/display_pkg.sv
// Purpose : shared display types -- glyph codes, segment patterns, result enum, game-state/turn codes.
// Latency : n/a (package, helper functions are purely combinational).
// Backpress: n/a.
// Contents: glyph_e / SEG_* constants, result_e, dispState_e, GS_* and TURN_* codes, sum-to-glyph helper.
package display_pkg;

  // Game-state and turn codes, kept identical to the game block's shared encoding.
  localparam logic [3:0] GS_IDLE   = 4'd0;
  localparam logic [3:0] GS_DEAL   = 4'd1;
  localparam logic [3:0] GS_PLAYER = 4'd2;
  localparam logic [3:0] GS_DEALER = 4'd3;
  localparam logic [3:0] GS_WIN    = 4'd4;
  localparam logic [3:0] GS_LOSE   = 4'd5;
  localparam logic [3:0] GS_TIE    = 4'd6;

  localparam logic [1:0] TURN_NONE   = 2'd0;
  localparam logic [1:0] TURN_PLAYER = 2'd1;
  localparam logic [1:0] TURN_DEALER = 2'd2;

  typedef enum logic [1:0] {RES_NONE, RES_WIN, RES_LOSE, RES_TIE} result_e;

  typedef enum logic {ST_LIVE, ST_HOLD} dispState_e;

  // Digits occupy codes 0-9 so a decimal value casts straight to its glyph.
  typedef enum logic [4:0] {
    GL_0, GL_1, GL_2, GL_3, GL_4, GL_5, GL_6, GL_7, GL_8, GL_9,
    GL_BLANK, GL_DASH, GL_P, GL_D, GL_U, GL_L, GL_O, GL_T, GL_I
  } glyph_e;

  typedef struct packed {
    glyph_e tens;
    glyph_e ones;
  } glyphPair_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_T     = 7'h07;
  localparam logic [6:0] SEG_I     = 7'h4F;

  function automatic result_e resultOf(input logic [3:0] gs);
    case (gs)
      GS_WIN:  return RES_WIN;
      GS_LOSE: return RES_LOSE;
      GS_TIE:  return RES_TIE;
      default: return RES_NONE;
    endcase
  endfunction

  // Two decimal digits for a 0-31 sum; the tens digit is blanked when zero.
  function automatic glyphPair_t sumGlyphs(input logic [4:0] sum);
    glyphPair_t g;
    if (sum >= 5'd30) begin
      g.tens = GL_3;
      g.ones = glyph_e'(sum - 5'd30);
    end else if (sum >= 5'd20) begin
      g.tens = GL_2;
      g.ones = glyph_e'(sum - 5'd20);
    end else if (sum >= 5'd10) begin
      g.tens = GL_1;
      g.ones = glyph_e'(sum - 5'd10);
    end else begin
      g.tens = GL_BLANK;
      g.ones = glyph_e'(sum);
    end
    return g;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Purpose : bundles the game-block inputs and the display outputs of score_display.
// Latency : n/a (wires only).
// Backpress: none; all signals are levels.
// Modports: master = game/board side (drives sums/state/turn), slave = score_display.
interface score_display_if;
  logic [4:0] i_playerHandSum;
  logic [4:0] i_dealerHandSum;
  logic [3:0] i_gameState;
  logic [1:0] i_turn;
  logic [6:0] o_hex5, o_hex4, o_hex3, o_hex2, o_hex1, o_hex0;
  logic       o_ledWin, o_ledLose, o_ledTie;
  logic       o_holdActive;
  logic [6:0] o_winCount, o_lossCount;

  modport master (
    output i_playerHandSum, i_dealerHandSum, i_gameState, i_turn,
    input  o_hex5, o_hex4, o_hex3, o_hex2, o_hex1, o_hex0,
    input  o_ledWin, o_ledLose, o_ledTie, o_holdActive, o_winCount, o_lossCount
  );

  modport slave (
    input  i_playerHandSum, i_dealerHandSum, i_gameState, i_turn,
    output o_hex5, o_hex4, o_hex3, o_hex2, o_hex1, o_hex0,
    output o_ledWin, o_ledLose, o_ledTie, o_holdActive, o_winCount, o_lossCount
  );
endinterface

// File: rtl/segment_encoder.sv
// Purpose : glyph code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency : combinational.
// Backpress: none.
// Ports   : i_glyph (glyph_e), o_seg (7-bit active-low segments).
module segment_encoder
  import display_pkg::*;
(
  input  glyph_e     i_glyph,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_glyph)
      GL_0:     o_seg = SEG_0;
      GL_1:     o_seg = SEG_1;
      GL_2:     o_seg = SEG_2;
      GL_3:     o_seg = SEG_3;
      GL_4:     o_seg = SEG_4;
      GL_5:     o_seg = SEG_5;
      GL_6:     o_seg = SEG_6;
      GL_7:     o_seg = SEG_7;
      GL_8:     o_seg = SEG_8;
      GL_9:     o_seg = SEG_9;
      GL_DASH:  o_seg = SEG_DASH;
      GL_P:     o_seg = SEG_P;
      GL_D:     o_seg = SEG_D;
      GL_U:     o_seg = SEG_U;
      GL_L:     o_seg = SEG_L;
      GL_O:     o_seg = SEG_O;
      GL_T:     o_seg = SEG_T;
      GL_I:     o_seg = SEG_I;
      default:  o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/score_display.sv
// Purpose : blackjack score display -- live sums/turn, frozen result snapshot with blinking status, tallies.
// Latency : live digits combinational; snapshot, LEDs, o_holdActive and tallies update one clock after a result cycle.
// Backpress: none; inputs are sampled every clock, outputs are levels.
// Ports   : i_clk, i_reset (async, active-high); bus (score_display_if.slave): sums/state/turn in,
//           hex5-4 dealer, hex3-2 player, hex1-0 status, result LEDs, o_holdActive, win/loss tallies out.
// Config  : define SCORE_DISPLAY_DEALER_MASK_EN to show "--" for the dealer sum during the player's turn.
module score_display
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES  = 100000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  score_display_if.slave bus
);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int BLINK_W = $clog2(2 * BLINK_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_CYCLES - 1);
  localparam logic [6:0]         TALLY_MAX  = 7'd99;

  dispState_e         state;
  logic [4:0]         snapPlayer, snapDealer;
  result_e            snapResult;
  logic [HOLD_W-1:0]  holdCnt;
  logic [BLINK_W-1:0] blinkCnt;
  logic [3:0]         prevGameState;
  logic [6:0]         winCount, lossCount;
  logic               ledWin, ledLose, ledTie, holdActive;

  result_e liveResult;
  logic    resultEntry;
  logic    latchNow;

  assign liveResult  = resultOf(bus.i_gameState);
  // A result only counts (and only re-latches during HOLD) on the cycle it first appears.
  assign resultEntry = (liveResult != RES_NONE) && (bus.i_gameState != prevGameState);
  assign latchNow    = (liveResult != RES_NONE) && ((state == ST_LIVE) || resultEntry);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_LIVE;
      snapPlayer    <= '0;
      snapDealer    <= '0;
      snapResult    <= RES_NONE;
      holdCnt       <= '0;
      blinkCnt      <= '0;
      prevGameState <= '0;
      winCount      <= '0;
      lossCount     <= '0;
      ledWin        <= 1'b0;
      ledLose       <= 1'b0;
      ledTie        <= 1'b0;
      holdActive    <= 1'b0;
    end else begin
      prevGameState <= bus.i_gameState;
      if (resultEntry && (liveResult == RES_WIN) && (winCount != TALLY_MAX))
        winCount <= winCount + 7'd1;
      if (resultEntry && (liveResult == RES_LOSE) && (lossCount != TALLY_MAX))
        lossCount <= lossCount + 7'd1;

      if (latchNow) begin
        state      <= ST_HOLD;
        snapPlayer <= bus.i_playerHandSum;
        snapDealer <= bus.i_dealerHandSum;
        snapResult <= liveResult;
        holdCnt    <= HOLD_LOAD;
        blinkCnt   <= '0;
        ledWin     <= (liveResult == RES_WIN);
        ledLose    <= (liveResult == RES_LOSE);
        ledTie     <= (liveResult == RES_TIE);
        holdActive <= 1'b1;
      end else if (state == ST_HOLD) begin
        blinkCnt <= (blinkCnt == BLINK_LAST) ? '0 : blinkCnt + 1'b1;
        if (holdCnt == '0) begin
          state      <= ST_LIVE;
          ledWin     <= 1'b0;
          ledLose    <= 1'b0;
          ledTie     <= 1'b0;
          holdActive <= 1'b0;
        end else begin
          holdCnt <= holdCnt - 1'b1;
        end
      end
    end
  end

  glyphPair_t livePlayerG, liveDealerG, snapPlayerG, snapDealerG;
  logic       blinkOn;
  glyph_e     glyph [6];
  logic [6:0] seg [6];

  assign livePlayerG = sumGlyphs(bus.i_playerHandSum);
  assign liveDealerG = sumGlyphs(bus.i_dealerHandSum);
  assign snapPlayerG = sumGlyphs(snapPlayer);
  assign snapDealerG = sumGlyphs(snapDealer);
  // First half of each blink period shows the glyph, second half is blank.
  assign blinkOn     = (blinkCnt < BLINK_HALF);

  always_comb begin
    for (int i = 0; i < 6; i++) glyph[i] = GL_BLANK;
    if (state == ST_HOLD) begin
      glyph[5] = snapDealerG.tens;
      glyph[4] = snapDealerG.ones;
      glyph[3] = snapPlayerG.tens;
      glyph[2] = snapPlayerG.ones;
      if (blinkOn) begin
        case (snapResult)
          RES_WIN:  begin glyph[1] = GL_U; glyph[0] = GL_P; end
          RES_LOSE: begin glyph[1] = GL_L; glyph[0] = GL_O; end
          RES_TIE:  begin glyph[1] = GL_T; glyph[0] = GL_I; end
          default:  begin glyph[1] = GL_BLANK; glyph[0] = GL_BLANK; end
        endcase
      end
    end else begin
`ifdef SCORE_DISPLAY_DEALER_MASK_EN
      if (bus.i_turn == TURN_PLAYER) begin
        glyph[5] = GL_DASH;
        glyph[4] = GL_DASH;
      end else begin
        glyph[5] = liveDealerG.tens;
        glyph[4] = liveDealerG.ones;
      end
`else
      glyph[5] = liveDealerG.tens;
      glyph[4] = liveDealerG.ones;
`endif
      glyph[3] = livePlayerG.tens;
      glyph[2] = livePlayerG.ones;
      case (bus.i_turn)
        TURN_PLAYER: glyph[1] = GL_P;
        TURN_DEALER: glyph[1] = GL_D;
        default:     glyph[1] = GL_BLANK;
      endcase
    end
  end

  for (genvar k = 0; k < 6; k++) begin : g_digit
    segment_encoder u_enc (.i_glyph(glyph[k]), .o_seg(seg[k]));
  end

  assign bus.o_hex5       = seg[5];
  assign bus.o_hex4       = seg[4];
  assign bus.o_hex3       = seg[3];
  assign bus.o_hex2       = seg[2];
  assign bus.o_hex1       = seg[1];
  assign bus.o_hex0       = seg[0];
  assign bus.o_ledWin     = ledWin;
  assign bus.o_ledLose    = ledLose;
  assign bus.o_ledTie     = ledTie;
  assign bus.o_holdActive = holdActive;
  assign bus.o_winCount   = winCount;
  assign bus.o_lossCount  = lossCount;
endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100000000, meaning the number of clocks a result stays frozen on the display (2 s at 50 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 12500000, meaning the half-period in clocks of the result-glyph blink.
REQ-003 SHALL have port i_clk  in  1  system clock, rising-edge.
REQ-004 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_playerHandSum  in  5  player hand sum from the game block, 0-31.
REQ-006 SHALL have port i_dealerHandSum  in  5  dealer hand sum from the game block, 0-31.
REQ-007 SHALL have port i_gameState  in  4  game FSM state code, from the shared game-state encoding.
REQ-008 SHALL have port i_turn  in  2  turn indicator (player/dealer/none), from the shared turn encoding.
REQ-009 SHALL have ports o_hex5..o_hex0  out  7 each  active-low segments {g,f,e,d,c,b,a}; hex5-4 dealer, hex3-2 player, hex1-0 status.
REQ-010 SHALL have ports o_ledWin, o_ledLose, o_ledTie  out  1 each  latched result, one-hot or all low.
REQ-011 SHALL have port o_holdActive  out  1  high while a result is frozen.
REQ-012 SHALL have ports o_winCount, o_lossCount  out  7 each  round tallies, 0-99.

Function
REQ-013 SHALL implement FSM LIVE/HOLD; LIVE shows the live inputs, HOLD shows the latched snapshot.
REQ-014 SHALL, in LIVE, on any cycle i_gameState is WIN/LOSE/TIE: latch both sums and the result, load the hold counter with HOLD_CYCLES-1, clear the blink counter, and enter HOLD on the next edge.
REQ-015 SHALL, in HOLD, decrement the hold counter each clock and return to LIVE on the clock after it reads 0 (HOLD lasts exactly HOLD_CYCLES clocks).
REQ-016 SHALL, in HOLD, re-latch on a new result state and restart the full hold period; the new snapshot SHALL replace the old one.
REQ-017 SHALL show each sum as two decimal digits (tens 0-3, ones 0-9); a leading zero SHALL be blanked (7 -> " 7", 0 -> " 0").
REQ-018 SHALL drive, in LIVE, hex1 with 'P' for the player's turn, 'd' for the dealer's turn, blank for no one's turn, and hex0 blank.
REQ-019 SHALL drive, in HOLD, hex1-0 with "UP" for a win, "Lo" for a loss or "tI" for a tie; these digits show the glyph for BLINK_CYCLES and are then blank for BLINK_CYCLES, glyph first.
REQ-020 SHALL hold the result LEDs and o_holdActive high only in HOLD.
REQ-021 SHALL increment a tally once per result episode, detected on entry (state is a result and the previous-cycle registered state differs); a held result state SHALL not count twice.
REQ-022 SHALL saturate the tallies at 99; a tie SHALL increment neither.
REQ-023 SHALL latency: live digits are combinational from the inputs; snapshot, LEDs and o_holdActive change one clock after the result cycle.

Reset
REQ-024 SHALL, on i_reset, immediately enter LIVE and clear the snapshot, hold/blink counters, previous-state register, tallies, LEDs and o_holdActive.
REQ-025 SHALL, on reset during HOLD, abort the hold with no result shown after release.

Configuration
REQ-026 SHALL, with macro SCORE_DISPLAY_DEALER_MASK_EN defined, drive hex5-4 with "--" while in LIVE and i_turn is player; the snapshot SHALL always be shown unmasked.
REQ-027 SHALL, with SCORE_DISPLAY_DEALER_MASK_EN undefined, always show the dealer sum, with no masking logic.

Structure
REQ-028 SHALL place glyph segment constants (digits 0-9, blank, dash, P, d, U, L, o, t, I) and the result enum in shared package display_pkg; state and turn codes come from the existing shared game-state and turn headers.
REQ-029 SHALL use one combinational sub-module, segment_encoder (glyph code -> active-low segments), instantiated per digit.

Verification
Use HOLD_CYCLES=8 and BLINK_CYCLES=2 for REQ-030 to REQ-034.
REQ-030 SHALL test: reset asserted mid-HOLD -> immediate LIVE, all LEDs 0, tallies 0, hex blank/dash per state.
REQ-031 SHALL test: LIVE with player 19, dealer 7, player turn -> hex3-2 "19", hex5-4 " 7" (or "--" with the mask macro), hex1 'P'.
REQ-032 SHALL test: WIN for one cycle with player 20, dealer 18 -> next clock o_holdActive=1, o_ledWin=1, hex shows "18","20","UP" blinking 2 on/2 off, o_winCount=1, LIVE after exactly 8 clocks.
REQ-033 SHALL test: LOSE during HOLD at clock 5 -> snapshot replaced, "Lo" shown, hold restarts at 8, o_lossCount=1.
REQ-034 SHALL test: 100 WIN pulses -> o_winCount saturates at 99; TIE pulse -> o_ledTie=1 and both tallies unchanged.
REQ-035 SHALL test: WIN held for 3 consecutive cycles -> o_winCount increments once.
